mode_sel: RTL and testbench

MODE_SEL -- requirements
Module: mode_sel

---
 rtl/mode_sel_pkg.sv | 24 ++
 rtl/debounce.sv | 45 ++++
 rtl/mode_sel.sv | 107 ++++++++++
 tb/tb_mode_sel.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mode_sel_pkg.sv
// rtl/mode_sel_pkg.sv - shared video-pipeline mode constants, types and helpers
package mode_sel_pkg;

  localparam int unsigned MODE_W     = 3;
  localparam int unsigned NMODES_MIN = 2;
  localparam int unsigned NMODES_MAX = 8;

  typedef logic [MODE_W-1:0] mode_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } next_state_e;

  function automatic mode_t mode_inc(input mode_t m, input int unsigned n);
    return (32'(m) == n - 1) ? '0 : m + mode_t'(1);
  endfunction

  function automatic mode_t mode_dec(input mode_t m, input int unsigned n);
    return (m == '0) ? mode_t'(n - 1) : m - mode_t'(1);
  endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - two-flop synchronizer plus counting debouncer with press-event output
module debounce #(
  parameter int unsigned DEB_CYCLES = 2000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic        sync_q1;
  logic        sync_q2;
  logic        d_q;
  logic        d_prev_q;
  logic [31:0] cnt_q;

  // The level only flips after the synchronized input has disagreed with it
  // for DEB_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      d_q      <= 1'b0;
      d_prev_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q1  <= btn_i;
      sync_q2  <= sync_q1;
      d_prev_q <= d_q;
      if (sync_q2 == d_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_CYCLES - 1) begin
        d_q   <= ~d_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign level_o = d_q;
  assign press_o = d_q & ~d_prev_q;

endmodule

// File: rtl/mode_sel.sv
// rtl/mode_sel.sv - button-driven mode selector with wrap-around and long-press reset to mode 0
module mode_sel
  import mode_sel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 2000000,
  parameter int unsigned LONG_CYCLES = 200000000,
  parameter int unsigned NMODES      = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              btn_next_i,
  input  logic              btn_prev_i,
  output logic [MODE_W-1:0] mode_o,
  output logic              mode_chg_o
);

  localparam int unsigned NM = (NMODES < NMODES_MIN) ? NMODES_MIN :
                               (NMODES > NMODES_MAX) ? NMODES_MAX : NMODES;

  logic        next_level;
  logic        next_press;
  logic        prev_level_unused;
  logic        prev_press;
  logic        long_press;

  next_state_e state_q, state_d;
  logic [31:0] hold_q, hold_d;
  mode_t       mode_q, mode_d;
  logic        chg_q;

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_next_i),
    .level_o (next_level),
    .press_o (next_press)
  );

  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (btn_prev_i),
    .level_o (prev_level_unused),
    .press_o (prev_press)
  );

  assign long_press = (state_q == PRESSED) && next_level && (hold_q == LONG_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mode_d  = mode_q;

    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (next_press) state_d = PRESSED;
      end
      PRESSED: begin
        if (!next_level) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (long_press) begin
          state_d = HELD;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      HELD: begin
        hold_d = '0;
        if (!next_level) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase

    // Long-press overrides a simultaneous prev press; simultaneous next+prev cancel.
    if (long_press) begin
      mode_d = '0;
    end else if (next_press && !prev_press) begin
      mode_d = mode_inc(mode_q, NM);
    end else if (prev_press && !next_press) begin
      mode_d = mode_dec(mode_q, NM);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      mode_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      chg_q   <= (mode_d != mode_q);
    end
  end

  assign mode_o     = mode_q;
  assign mode_chg_o = chg_q;

endmodule

// File: tb/tb_mode_sel.sv
// tb/tb_mode_sel.sv - scoreboard bench for mode_sel with directed button scenarios
module tb_mode_sel;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int NM   = 8;
  localparam int LAT  = DEB + 3;

  logic       clk_i      = 1'b0;
  logic       rst_ni     = 1'b0;
  logic       btn_next_i = 1'b0;
  logic       btn_prev_i = 1'b0;
  logic [2:0] mode_o;
  logic       mode_chg_o;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    int mode;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  mode_sel #(
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG),
    .NMODES      (NM)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .btn_next_i (btn_next_i),
    .btn_prev_i (btn_prev_i),
    .mode_o     (mode_o),
    .mode_chg_o (mode_chg_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic expect_pulse(input int m, input int dly);
    exp_t e;
    e.mode = m;
    e.cyc  = cyc + dly;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic nxt, input logic prv, input int hi, input int lo);
    btn_next_i = nxt;
    btn_prev_i = prv;
    step(hi);
    btn_next_i = 1'b0;
    btn_prev_i = 1'b0;
    step(lo);
  endtask

  // Every pulse must match the oldest queued expectation in both value and cycle.
  always @(negedge clk_i) begin
    if (mode_chg_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: mode_o=%0d at cycle %0d, no pulse expected", mode_o, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_mode", int'(mode_o), e.mode);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    // Scenario 1: reset
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_mode", int'(mode_o), 0);
      chk("rst_chg", int'(mode_chg_o), 0);
    end
    step(1);
    rst_ni = 1'b1;
    step(3);
    chk("post_rst_mode", int'(mode_o), 0);
    chk("post_rst_chg", int'(mode_chg_o), 0);

    // Scenario 2: eight next presses, wrap 7 -> 0
    for (int i = 1; i <= 8; i++) begin
      expect_pulse(i % NM, LAT);
      press(1'b1, 1'b0, 10, 10);
    end
    chk("s2_final_mode", int'(mode_o), 0);

    // Scenario 3: bounce never settles long enough
    for (int i = 0; i < 6; i++) begin
      btn_next_i = (i % 2 == 0);
      step(2);
    end
    btn_next_i = 1'b0;
    step(20);
    chk("s3_bounce_mode", int'(mode_o), 0);

    // Scenario 4: prev wraps 0 -> 7, simultaneous presses cancel
    expect_pulse(7, LAT);
    press(1'b0, 1'b1, 10, 10);
    chk("s4_prev_mode", int'(mode_o), 7);
    press(1'b1, 1'b1, 10, 10);
    chk("s4_both_mode", int'(mode_o), 7);

    // Scenario 5: from mode 2, long press forces 0 twenty cycles after the step
    for (int i = 0; i < 3; i++) begin
      expect_pulse(i, LAT);
      press(1'b1, 1'b0, 10, 10);
    end
    chk("s5_start_mode", int'(mode_o), 2);
    expect_pulse(3, LAT);
    expect_pulse(0, LAT + LONG);
    press(1'b1, 1'b0, 40, 20);
    chk("s5_long_mode", int'(mode_o), 0);

    // Scenario 6: reset mid-hold at mode 5, button kept high through release
    for (int i = 1; i <= 4; i++) begin
      expect_pulse(i, LAT);
      press(1'b1, 1'b0, 10, 10);
    end
    expect_pulse(5, LAT);
    btn_next_i = 1'b1;
    step(12);
    chk("s6_pre_rst_mode", int'(mode_o), 5);
    rst_ni = 1'b0;
    step(2);
    chk("s6_rst_mode", int'(mode_o), 0);
    chk("s6_rst_chg", int'(mode_chg_o), 0);
    rst_ni = 1'b1;
    expect_pulse(1, LAT);
    step(10);
    btn_next_i = 1'b0;
    step(20);
    chk("s6_final_mode", int'(mode_o), 1);

    chk("missing_pulses", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
